// File: rtl/mc_fork_collect.sv
// Output stage of the multicast BLESS router: registers granted flit copies onto the
// links and parks multicast flits with unserved destinations in a recirculation FIFO.
module mc_fork_collect #(
    parameter int FLIT_W    = 64,
    parameter int NPORT     = 4,
    parameter int REC_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NPORT-1:0]        in_valid,
    input  logic [NPORT*FLIT_W-1:0] in_flit,
    input  logic [NPORT-1:0]        in_mc,
    input  logic [NPORT*NPORT-1:0]  in_apv,
    input  logic [NPORT*NPORT-1:0]  in_ppv_rem,
    output logic [NPORT-1:0]        out_valid,
    output logic [NPORT*FLIT_W-1:0] out_flit,
    output logic [NPORT*2-1:0]      out_src,
    output logic                    rec_valid,
    output logic [FLIT_W-1:0]       rec_flit,
    output logic [NPORT-1:0]        rec_ppv,
    input  logic                    rec_ready,
    output logic [CNT_W-1:0]        numFlit_out,
    output logic                    conflict_err,
    output logic                    rec_ovf
);

    localparam int AW = $clog2(REC_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = FLIT_W + NPORT;

    logic [NPORT-1:0]        out_valid_q, out_valid_d;
    logic [NPORT*FLIT_W-1:0] out_flit_q, out_flit_d;
    logic [NPORT*2-1:0]      out_src_q, out_src_d;
    logic                    conflict_q, conflict_d;
    logic                    ovf_q, ovf_d;
    logic [EW-1:0]           mem_q [REC_DEPTH];
    logic [EW-1:0]           mem_d [REC_DEPTH];
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CNT_W-1:0]        num_q, num_d;
    logic                    pop;
    logic [CW-1:0]           cap;
    logic [CW-1:0]           n_push;
    int                      flit_sum;

    // Scanning slots high-to-low lets the lowest index overwrite, so it wins the port.
    always_comb begin
        out_valid_d = '0;
        out_flit_d  = out_flit_q;
        out_src_d   = out_src_q;
        conflict_d  = conflict_q;
        for (int p = 0; p < NPORT; p++) begin
            for (int i = NPORT - 1; i >= 0; i--) begin
                if (in_valid[i] && in_apv[i*NPORT+p]) begin
                    if (out_valid_d[p]) conflict_d = 1'b1;
                    out_valid_d[p]                = 1'b1;
                    out_flit_d[p*FLIT_W +: FLIT_W] = in_flit[i*FLIT_W +: FLIT_W];
                    out_src_d[p*2 +: 2]           = 2'(i);
                end
            end
        end
    end

    // The pop frees its slot first; accepting lowest slots first drops the highest ones.
    always_comb begin
        pop    = (count_q != '0) && rec_ready;
        cap    = CW'(REC_DEPTH) - count_q + CW'(pop);
        n_push = '0;
        ovf_d  = ovf_q;
        mem_d  = mem_q;
        for (int i = 0; i < NPORT; i++) begin
            if (in_valid[i] && in_mc[i] && (in_ppv_rem[i*NPORT +: NPORT] != '0)) begin
                if (n_push < cap) begin
                    mem_d[wr_ptr_q + n_push[AW-1:0]] = {in_flit[i*FLIT_W +: FLIT_W],
                                                        in_ppv_rem[i*NPORT +: NPORT]};
                    n_push = n_push + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
        count_d  = count_q - CW'(pop) + n_push;
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + n_push[AW-1:0];
    end

    always_comb begin
        flit_sum = 0;
        for (int i = 0; i < NPORT; i++) flit_sum = flit_sum + int'(in_valid[i]);
        if (count_d != '0) flit_sum = flit_sum + 1;
        if (flit_sum > NPORT + 1) flit_sum = NPORT + 1;
        num_d = CNT_W'(flit_sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= '0;
            out_flit_q  <= '0;
            out_src_q   <= '0;
            conflict_q  <= 1'b0;
            ovf_q       <= 1'b0;
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            num_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_src_q   <= out_src_d;
            conflict_q  <= conflict_d;
            ovf_q       <= ovf_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            num_q       <= num_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_flit     = out_flit_q;
    assign out_src      = out_src_q;
    assign rec_valid    = (count_q != '0);
    assign rec_flit     = mem_q[rd_ptr_q][EW-1:NPORT];
    assign rec_ppv      = mem_q[rd_ptr_q][NPORT-1:0];
    assign numFlit_out  = num_q;
    assign conflict_err = conflict_q;
    assign rec_ovf      = ovf_q;

endmodule
